// File: rtl/prga_decrypt.sv
// -----------------------------------------------------------------------------
// prga_decrypt
//   RC4 pseudo-random generation stage. It reads an S-box that the
//   key-scheduling stage has already filled, and a length-prefixed ciphertext
//   memory. It writes the length-prefixed plaintext to a third memory. While
//   running, it permutes S in place.
//
//   Ports
//     clk, rst            clock, asynchronous active-high reset
//     en / rdy            start request / idle indication (en sampled when rdy=1)
//     s_addr, s_rddata,   S memory: address, read data (1-cycle latency),
//     s_wrdata, s_wren    write data, write enable
//     ct_addr, ct_rddata  ciphertext memory: address, read data (1-cycle latency)
//     pt_addr, pt_wrdata, plaintext memory: address, write data, write enable
//     pt_wren
//
//   rdy and both write enables come straight from flops, so they are
//   glitch-free.
//   The addresses and write data are decoded from registered state. Some of
//   them also depend on read data that arrives in the same cycle it is needed
//   (j+S[i], pad^CT[k]). Registering those values would add a cycle to every
//   dependent step.
// -----------------------------------------------------------------------------
module prga_decrypt #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_rddata,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [DATA_W-1:0] ct_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [DATA_W-1:0] pt_wrdata,
    output logic              pt_wren
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_LEN = 4'd1,
        WR_LEN = 4'd2,
        RD_SI  = 4'd3,
        CALC_J = 4'd4,
        RD_SJ  = 4'd5,
        WR_SI  = 4'd6,
        WR_SJ  = 4'd7,
        RD_PAD = 4'd8,
        WR_PT  = 4'd9,
        DONE   = 4'd10
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] i_r;
    logic [ADDR_W-1:0] j_r;
    logic [ADDR_W-1:0] k_r;
    logic [ADDR_W-1:0] len_r;
    logic [DATA_W-1:0] si_r;
    logic [DATA_W-1:0] sj_r;
    logic              rdy_r;
    logic              s_wren_r;
    logic              pt_wren_r;
    logic [ADDR_W-1:0] s_addr_s;
    logic [DATA_W-1:0] s_wrdata_s;
    logic [ADDR_W-1:0] ct_addr_s;
    logic [ADDR_W-1:0] pt_addr_s;
    logic [DATA_W-1:0] pt_wrdata_s;

    // State register and flop-driven handshake/write-enable outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            rdy_r     <= 1'b1;
            s_wren_r  <= 1'b0;
            pt_wren_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            rdy_r     <= (state_s == IDLE) || (state_s == DONE);
            s_wren_r  <= (state_s == WR_SI) || (state_s == WR_SJ);
            pt_wren_r <= (state_s == WR_LEN) || (state_s == WR_PT);
        end
    end

    // Next-state decode plus per-state address and write-data selection.
    always_comb begin
        state_s     = state_r;
        s_addr_s    = ADDR_ZERO;
        s_wrdata_s  = DATA_ZERO;
        ct_addr_s   = ADDR_ZERO;
        pt_addr_s   = ADDR_ZERO;
        pt_wrdata_s = DATA_ZERO;
        case (state_r)
            IDLE, DONE: begin
                // DONE also accepts en, so a held en starts back-to-back runs.
                if (en) begin
                    state_s = RD_LEN;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_LEN: begin
                ct_addr_s = ADDR_ZERO;
                state_s   = WR_LEN;
            end
            WR_LEN: begin
                pt_addr_s   = ADDR_ZERO;
                pt_wrdata_s = ct_rddata;
                if (ct_rddata == DATA_ZERO) begin
                    state_s = DONE;
                end else begin
                    state_s = RD_SI;
                end
            end
            RD_SI: begin
                s_addr_s = i_r + ADDR_ONE;
                state_s  = CALC_J;
            end
            CALC_J: begin
                // S[i] arrives this cycle; address S[j+S[i]] right away.
                s_addr_s = j_r + ADDR_W'(s_rddata);
                state_s  = RD_SJ;
            end
            RD_SJ: begin
                s_addr_s = j_r;
                state_s  = WR_SI;
            end
            WR_SI: begin
                s_addr_s   = i_r;
                s_wrdata_s = sj_r;
                state_s    = WR_SJ;
            end
            WR_SJ: begin
                s_addr_s   = j_r;
                s_wrdata_s = si_r;
                state_s    = RD_PAD;
            end
            RD_PAD: begin
                // Both swap writes have landed, so this reads the post-swap S.
                s_addr_s  = ADDR_W'(si_r) + ADDR_W'(sj_r);
                ct_addr_s = k_r;
                state_s   = WR_PT;
            end
            WR_PT: begin
                pt_addr_s   = k_r;
                pt_wrdata_s = s_rddata ^ ct_rddata;
                // The loop ends on the k==len compare, not on wrap, so len=255 works.
                if (k_r == len_r) begin
                    state_s = DONE;
                end else begin
                    state_s = RD_SI;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // RC4 indices, loop counter, length and swap operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_r   <= ADDR_ZERO;
            j_r   <= ADDR_ZERO;
            k_r   <= ADDR_ZERO;
            len_r <= ADDR_ZERO;
            si_r  <= DATA_ZERO;
            sj_r  <= DATA_ZERO;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (en) begin
                        i_r <= ADDR_ZERO;
                        j_r <= ADDR_ZERO;
                        k_r <= ADDR_ZERO;
                    end
                end
                WR_LEN: begin
                    len_r <= ADDR_W'(ct_rddata);
                    k_r   <= ADDR_ONE;
                end
                RD_SI: begin
                    i_r <= i_r + ADDR_ONE;
                end
                CALC_J: begin
                    si_r <= s_rddata;
                    j_r  <= j_r + ADDR_W'(s_rddata);
                end
                RD_SJ: begin
                    sj_r <= s_rddata;
                end
                WR_PT: begin
                    if (k_r != len_r) begin
                        k_r <= k_r + ADDR_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rdy       = rdy_r;
    assign s_wren    = s_wren_r;
    assign pt_wren   = pt_wren_r;
    assign s_addr    = s_addr_s;
    assign s_wrdata  = s_wrdata_s;
    assign ct_addr   = ct_addr_s;
    assign pt_addr   = pt_addr_s;
    assign pt_wrdata = pt_wrdata_s;

endmodule

// File: tb/tb_prga_decrypt.sv
// -----------------------------------------------------------------------------
// tb_prga_decrypt
//   Directed bench for prga_decrypt. The S, CT and PT memories are modelled
//   inside the tick task as synchronous-read RAMs. Before each run, a software
//   RC4 PRGA model pushes the expected PT writes ({addr,data}) into a queue.
//   Each observed PT write pops that queue and is compared against the
//   popped entry.
// -----------------------------------------------------------------------------
module tb_prga_decrypt;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    logic [7:0]  s_mem   [256];
    logic [7:0]  ct_mem  [256];
    logic [7:0]  pt_mem  [256];
    logic [7:0]  s_ref   [256];
    logic [7:0]  s_save  [256];
    logic [7:0]  ct_snap [256];
    logic [7:0]  pt_snap [256];
    logic [7:0]  pads    [256];
    logic [15:0] exp_q   [$];

    int   errors = 0;
    int   checks = 0;
    int   n_s_wr;
    int   n_pt_wr;
    int   both_wr = 0;
    logic rdy_smp;

    prga_decrypt #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, apply memory read/write just after posedge.
    task automatic tick();
        logic [7:0]  sa, sw, ca, pa, pw, rs, rc;
        logic        swe, pwe;
        logic [15:0] e;
        @(negedge clk);
        sa = s_addr; sw = s_wrdata; swe = s_wren;
        ca = ct_addr;
        pa = pt_addr; pw = pt_wrdata; pwe = pt_wren;
        rdy_smp = rdy;
        if (swe) n_s_wr++;
        if (swe && pwe) both_wr++;
        if (pwe) begin
            n_pt_wr++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL pt_extra_write: got addr=%02h data=%02h, required no write", pa, pw);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pt_write", {16'h0000, pa, pw}, {16'h0000, e});
            end
        end
        @(posedge clk);
        #1;
        rs = s_mem[sa];
        rc = ct_mem[ca];
        if (swe) s_mem[sa] = sw;
        if (pwe) pt_mem[pa] = pw;
        s_rddata  = rs;
        ct_rddata = rc;
    endtask

    function automatic int ndiff(input logic [7:0] a [256], input logic [7:0] b [256]);
        int n = 0;
        for (int x = 0; x < 256; x++) if (a[x] !== b[x]) n++;
        return n;
    endfunction

    // Software RC4 PRGA on s_ref: pads[1..len], with i and j starting at 0.
    task automatic gen_pads(input int len);
        int i, j;
        logic [7:0] t;
        i = 0; j = 0;
        for (int k = 1; k <= len; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(s_ref[i])) % 256;
            t = s_ref[i]; s_ref[i] = s_ref[j]; s_ref[j] = t;
            pads[k] = s_ref[(int'(s_ref[i]) + int'(s_ref[j])) % 256];
        end
    endtask

    task automatic model_run();
        int len;
        len = int'(ct_mem[0]);
        exp_q.push_back({8'h00, ct_mem[0]});
        gen_pads(len);
        for (int k = 1; k <= len; k++) exp_q.push_back({8'(k), pads[k] ^ ct_mem[k]});
    endtask

    task automatic identity_s();
        for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
    endtask

    task automatic rand_perm_s();
        int r;
        logic [7:0] t;
        identity_s();
        for (int x = 255; x > 0; x--) begin
            r = int'($urandom_range(x, 0));
            t = s_mem[x]; s_mem[x] = s_mem[r]; s_mem[r] = t;
        end
    endtask

    task automatic rand_ct(input logic [7:0] len);
        ct_mem[0] = len;
        for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom_range(255, 0));
    endtask

    task automatic fill_pt(input logic [7:0] v);
        for (int x = 0; x < 256; x++) pt_mem[x] = v;
    endtask

    // Pulse en, then wait (bounded) for rdy to come back.
    task automatic run_until_rdy(input string tag, input int budget);
        int n;
        logic ok;
        en = 1'b1; tick(); en = 1'b0;
        n = 0; ok = 1'b0;
        while (!ok && n < budget) begin
            tick(); n++;
            if (rdy_smp) ok = 1'b1;
        end
        check({tag, "_done_in_budget"}, {31'h0, ok}, 32'h1);
    endtask

    task automatic prep(input logic [7:0] pt_fill);
        fill_pt(pt_fill);
        s_ref = s_mem;
        exp_q.delete();
        n_s_wr = 0; n_pt_wr = 0;
    endtask

    initial begin
        logic [7:0] key [3];
        string msg;
        int j, len, bad, n;
        logic [7:0] t;
        logic busy, done1, done2;

        rst = 1'b1; en = 1'b0; s_rddata = 8'h00; ct_rddata = 8'h00;
        n_s_wr = 0; n_pt_wr = 0;
        identity_s(); rand_ct(8'h10); fill_pt(8'hEE);

        // Reset and idle.
        repeat (3) tick();
        check("reset_rdy", {31'h0, rdy}, 32'h1);
        check("reset_s_wren", {31'h0, s_wren}, 32'h0);
        check("reset_pt_wren", {31'h0, pt_wren}, 32'h0);
        rst = 1'b0;
        s_save = s_mem; ct_snap = ct_mem; pt_snap = pt_mem;
        n_s_wr = 0; n_pt_wr = 0;
        repeat (100) tick();
        check("idle_writes", n_s_wr + n_pt_wr, 32'h0);
        check("idle_mem_unchanged", ndiff(s_mem, s_save) + ndiff(ct_mem, ct_snap) + ndiff(pt_mem, pt_snap), 32'h0);
        check("idle_rdy", {31'h0, rdy}, 32'h1);

        // Length 0.
        identity_s(); rand_ct(8'h00); prep(8'h5A); model_run();
        run_until_rdy("len0", 10);
        check("len0_pt0", {24'h0, pt_mem[0]}, 32'h00);
        check("len0_pt1_untouched", {24'h0, pt_mem[1]}, 32'h5A);
        check("len0_pt_writes", n_pt_wr, 32'd1);
        check("len0_s_writes", n_s_wr, 32'd0);
        check("len0_queue_empty", exp_q.size(), 32'd0);

        // Identity S, length 1: i=j=1, so S stays unchanged.
        identity_s(); ct_mem[0] = 8'h01; ct_mem[1] = 8'h00; prep(8'h00); model_run();
        s_save = s_mem;
        run_until_rdy("len1", 40);
        check("len1_pt1", {24'h0, pt_mem[1]}, 32'h02);
        check("len1_s_unchanged", ndiff(s_mem, s_save), 32'd0);
        check("len1_queue_empty", exp_q.size(), 32'd0);

        // Identity S, length 2.
        identity_s(); ct_mem[0] = 8'h02; ct_mem[1] = 8'h00; ct_mem[2] = 8'hAA; prep(8'h00); model_run();
        run_until_rdy("len2", 60);
        check("len2_pt1", {24'h0, pt_mem[1]}, 32'h02);
        check("len2_pt2", {24'h0, pt_mem[2]}, 32'hAF);
        check("len2_s2", {24'h0, s_mem[2]}, 32'h03);
        check("len2_s3", {24'h0, s_mem[3]}, 32'h02);
        check("len2_queue_empty", exp_q.size(), 32'd0);

        // Reset in the middle of a 255-byte run.
        rand_perm_s(); rand_ct(8'hFF); prep(8'h00); model_run();
        en = 1'b1; tick(); en = 1'b0;
        repeat (50) tick();
        rst = 1'b1;
        #1;
        check("abort_rdy", {31'h0, rdy}, 32'h1);
        check("abort_wrens", {30'h0, s_wren, pt_wren}, 32'h0);
        check("abort_addrs", {8'h0, s_addr, ct_addr, pt_addr}, 32'h0);
        exp_q.delete();
        s_save = s_mem; pt_snap = pt_mem;
        n_s_wr = 0; n_pt_wr = 0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        check("abort_no_writes", n_s_wr + n_pt_wr, 32'd0);
        check("abort_mem_kept", ndiff(s_mem, s_save) + ndiff(pt_mem, pt_snap), 32'd0);

        // A fresh run after the abort.
        rand_perm_s(); rand_ct(8'h10); prep(8'h00); model_run();
        run_until_rdy("post_abort", 200);
        check("post_abort_queue_empty", exp_q.size(), 32'd0);
        check("post_abort_pt_writes", n_pt_wr, 32'd17);
        check("post_abort_s_final", ndiff(s_mem, s_ref), 32'd0);

        // Back-to-back: en held high across two runs, and the second run restarts i=j=0.
        rand_perm_s(); rand_ct(8'h05); prep(8'h00); model_run(); model_run();
        en = 1'b1; tick();
        n = 0; busy = 1'b0; done1 = 1'b0;
        while (!done1 && n < 100) begin
            tick(); n++;
            if (!rdy_smp) busy = 1'b1;
            else if (busy) done1 = 1'b1;
        end
        en = 1'b0;
        check("b2b_first_done", {31'h0, done1}, 32'h1);
        n = 0; busy = 1'b0; done2 = 1'b0;
        while (!done2 && n < 100) begin
            tick(); n++;
            if (!rdy_smp) busy = 1'b1;
            else if (busy) done2 = 1'b1;
        end
        check("b2b_second_done", {31'h0, done2}, 32'h1);
        check("b2b_queue_empty", exp_q.size(), 32'd0);
        check("b2b_pt_writes", n_pt_wr, 32'd12);
        check("b2b_s_final", ndiff(s_mem, s_ref), 32'd0);

        // Full system: software KSA with key 00 03 3C, then decrypt a known message.
        key[0] = 8'h00; key[1] = 8'h03; key[2] = 8'h3C;
        for (int x = 0; x < 256; x++) s_ref[x] = 8'(x);
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + int'(s_ref[x]) + int'(key[x % 3])) % 256;
            t = s_ref[x]; s_ref[x] = s_ref[j]; s_ref[j] = t;
        end
        s_mem = s_ref; s_save = s_ref;
        msg = "PRGA decrypt check with key 00033C";
        len = msg.len();
        gen_pads(len);
        ct_mem[0] = 8'(len);
        for (int k = 1; k <= len; k++) ct_mem[k] = 8'(msg[k-1]) ^ pads[k];
        prep(8'h00);
        s_ref = s_save;
        model_run();
        run_until_rdy("full", 400);
        bad = 0;
        for (int k = 1; k <= len; k++) if (pt_mem[k] !== 8'(msg[k-1])) bad++;
        check("full_pt0_len", {24'h0, pt_mem[0]}, len);
        check("full_plaintext_bytes", bad, 32'd0);
        check("full_queue_empty", exp_q.size(), 32'd0);
        check("full_s_final", ndiff(s_mem, s_ref), 32'd0);

        check("wren_exclusive", both_wr, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prga_decrypt.md
Name: prga_decrypt

Overview:
- Reads the S-box array that the key-scheduling stage has already written, together with a length-prefixed ciphertext memory.
- Runs the RC4 pseudo-random generation algorithm and writes the length-prefixed plaintext to a third memory.
- Sits downstream of the key-scheduling block in the task top level and shares the S memory with it through a mux driven by the top-level controller.
- Uses an en/rdy handshake.

Parameters:
- ADDR_W, 8, address width of the S, CT and PT memories (256 entries).
- DATA_W, 8, data width of all memories.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  start request; sampled only when rdy=1.
- rdy  out  1  high when idle and able to accept en.
- s_addr  out  8  S memory address.
- s_rddata  in  8  S memory read data, valid 1 cycle after s_addr is presented.
- s_wrdata  out  8  S memory write data.
- s_wren  out  1  S memory write enable.
- ct_addr  out  8  ciphertext memory address.
- ct_rddata  in  8  ciphertext read data, 1-cycle latency.
- pt_addr  out  8  plaintext memory address.
- pt_wrdata  out  8  plaintext write data.
- pt_wren  out  1  plaintext write enable.

Behaviour:
- Reset (asynchronous, any state):
  - rdy=1; s_wren=0; pt_wren=0.
  - All addresses and write data are 0.
  - i, j and k are cleared; state=IDLE.
- Reset mid-run aborts immediately. Memory contents already written are left as they are. The block must not issue any further write.
- Handshake:
  - en && rdy at a rising edge starts a run; rdy falls on the following cycle.
  - en is ignored while rdy=0.
  - rdy returns to 1 in the cycle after the last plaintext write.
  - en held high at completion starts a new run immediately; it is not an error.
- Memory model: every read takes 1 cycle. The address is registered in cycle N and the data is used in cycle N+1. Writes take effect at the edge on which wren=1.
- Algorithm, all arithmetic mod 256 with 8-bit wrap and no carry kept:
  - len = CT[0]; PT[0] = len; i=0; j=0.
  - For k = 1..len:
    - i = i+1
    - j = j + S[i]
    - swap S[i] and S[j]
    - pad = S[S[i]+S[j]], using the post-swap values
    - PT[k] = pad ^ CT[k]
- States:
  - IDLE: wait for en.
  - RD_LEN: ct_addr=0.
  - WR_LEN: pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1; latch len.
    - len=0 -> DONE.
    - otherwise k=1 -> RD_SI.
  - RD_SI: i+1, s_addr=i+1.
  - CALC_J: latch si; j=j+si; s_addr=j.
  - RD_SJ: latch sj.
  - WR_SI: s_addr=i, s_wrdata=sj, s_wren=1.
  - WR_SJ: s_addr=j, s_wrdata=si, s_wren=1.
  - RD_PAD: s_addr=si+sj, ct_addr=k.
  - WR_PT: pt_addr=k, pt_wrdata=s_rddata^ct_rddata, pt_wren=1.
    - k==len -> DONE.
    - otherwise k+1 -> RD_SI.
  - DONE: rdy=1 -> IDLE.
- Case i==j: both swap writes target the same address with the same value; the result is unchanged S.
- Case len=255: k counts up to 255 with no overflow. The loop ends on the k==len compare, never on wrap.
- Write enables are asserted for exactly one cycle per write and never both in the same cycle. Exactly len+1 PT writes occur per run.
- i and j persist only within a run; each new run restarts them at 0.

Test Plan:
- Reset/idle: assert rst for 3 cycles -> rdy=1, s_wren=0, pt_wren=0. Holding en=0 for 100 cycles leaves all memories unchanged.
- Length 0: CT[0]=0x00, pulse en -> PT[0]=0x00, no other PT or S writes, rdy=1 within 10 cycles.
- Identity S, length 1: S[x]=x, CT={0x01,0x00}.
  - Required: PT[1]=0x02.
  - Required: S unchanged, since i=j=1.
- Identity S, length 2: CT={0x02,0x00,0xAA}.
  - Required: PT[1]=0x02, PT[2]=0xAF (pad S[5]=0x05).
  - Required: S[2]=0x03, S[3]=0x02 afterwards.
- Reset mid-run: start a length-0xFF run and assert rst after 50 cycles.
  - Required: rdy=1 the same cycle and no writes after rst.
  - Required: a subsequent run with fresh memories produces correct output.
- Back-to-back and full system: en held high across two runs -> second run restarts at i=j=0. A full run after the key-scheduling stage (key 0x00033C) produces PT matching the reference software model byte-for-byte.
